// File: rtl/ring_seq_ctrl_if.sv
// Run-control and output-handshake bundle for ring_seq_ctrl.
// master: the run requester / consumer side; slave: the sequencer.
interface ring_seq_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [3:0]       seed;
  logic [CNT_W-1:0] steps;
  logic             abort;
  logic             out_ready;
  logic [3:0]       val_out;
  logic             val_valid;
  logic             busy;
  logic             done;
  logic             seed_err;
  logic             wrap;

  modport master (
    output start, seed, steps, abort, out_ready,
    input  val_out, val_valid, busy, done, seed_err, wrap
  );

  modport slave (
    input  start, seed, steps, abort, out_ready,
    output val_out, val_valid, busy, done, seed_err, wrap
  );
endinterface

// File: rtl/ring_seq_ctrl.sv
// Ring/feedback sequence generator with a valid/ready output stream.
// A run loads a 4-bit feedback register from the seed and emits `steps`
// values, advancing once per accepted transfer, then pulses done.
module ring_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  ring_seq_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       q_reg, q_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [3:0]       seed_eff_reg, seed_eff_next;
  logic             adv_reg, adv_next;
  logic             seed_err_reg, seed_err_next;

  logic [3:0]       seed_eff;
  logic [3:0]       q_adv;
  logic             xfer;

  // A zero seed would lock the register at zero, so it is replaced by 0001.
  assign seed_eff = (bus.seed == 4'b0000) ? 4'b0001 : bus.seed;

  // Shift toward bit 0 with Q[0]^Q[1] fed back into bit 3 (period 15).
  assign q_adv = {q_reg[0] ^ q_reg[1], q_reg[3], q_reg[2], q_reg[1]};

  // Abort wins over out_ready, so an aborting edge never transfers.
  assign xfer = (state_reg == RUN) && bus.out_ready && !bus.abort;

  // Next-state and datapath updates; everything holds unless changed below.
  always_comb begin
    state_next    = state_reg;
    q_next        = q_reg;
    cnt_next      = cnt_reg;
    seed_eff_next = seed_eff_reg;
    adv_next      = adv_reg;
    seed_err_next = seed_err_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          q_next        = seed_eff;
          seed_eff_next = seed_eff;
          cnt_next      = bus.steps;
          adv_next      = 1'b0;
          seed_err_next = (bus.seed == 4'b0000);
          state_next    = (bus.steps == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_next = IDLE;
        end else if (xfer) begin
          q_next   = q_adv;
          adv_next = 1'b1;
          if (cnt_reg <= CNT_W'(1)) begin
            cnt_next   = '0;
            state_next = DONE;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      q_reg        <= 4'b0001;
      cnt_reg      <= '0;
      seed_eff_reg <= 4'b0001;
      adv_reg      <= 1'b0;
      seed_err_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      q_reg        <= q_next;
      cnt_reg      <= cnt_next;
      seed_eff_reg <= seed_eff_next;
      adv_reg      <= adv_next;
      seed_err_reg <= seed_err_next;
    end
  end

  assign bus.val_out   = q_reg;
  assign bus.val_valid = (state_reg == RUN);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.seed_err  = seed_err_reg;
  assign bus.wrap      = (state_reg == RUN) && adv_reg && (q_reg == seed_eff_reg);

endmodule

// File: doc/ring_seq_ctrl.md
RING_SEQ_CTRL -- requirements
Module: ring_seq_ctrl

Interface
REQ-001 Parameter CNT_W, default 8, SHALL set the width of the step-count input and the internal remaining-step counter.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset: low forces reset state immediately, independent of clk.
REQ-004 start  input  1  SHALL be the run request, sampled only in IDLE.
REQ-005 seed  input  4  SHALL be the initial 4-bit register value, captured with start.
REQ-006 steps  input  CNT_W  SHALL be the number of values to emit, captured with start.
REQ-007 abort  input  1  SHALL cancel an active run.
REQ-008 out_ready  input  1  SHALL be the consumer-ready signal for the output handshake.
REQ-009 val_out  output  4  SHALL carry the current feedback-register value.
REQ-010 val_valid  output  1  SHALL mark val_out as valid.
REQ-011 busy  output  1  SHALL be high in RUN and DONE.
REQ-012 done  output  1  SHALL be a one-cycle pulse at normal completion.
REQ-013 seed_err  output  1  SHALL be high for a run whose captured seed was 4'b0000; it is held until the next accepted start or reset.
REQ-014 wrap  output  1  SHALL be high when val_valid=1 and val_out equals the effective seed, after at least one advance.

Function
REQ-015 The internal 4-bit register Q SHALL advance to {Q[0]^Q[1], Q[3], Q[2], Q[1]}, i.e. shift toward bit 0 with Q[0]^Q[1] fed into bit 3. This gives a period of 15 over the nonzero states.
REQ-016 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE with start=1 and steps!=0, the edge SHALL load Q with the effective seed, load the counter with steps, and enter RUN.
  - The effective seed is seed, or 4'b0001 if seed==0.
REQ-018 In IDLE with start=1 and steps==0, the edge SHALL load Q as in REQ-017 and enter DONE directly, with no valid values emitted.
REQ-019 In RUN, val_valid SHALL be 1 and val_out SHALL equal Q.
  - First val_valid occurs in the cycle after the start edge (latency 1).
REQ-020 A transfer SHALL occur on an edge where val_valid=1 and out_ready=1.
  - Each transfer advances Q once and decrements the counter.
  - The counter never underflows.
REQ-021 With out_ready=0, val_out and val_valid SHALL hold stable, and Q and the counter SHALL not change.
REQ-022 When a transfer occurs with counter==1, the FSM SHALL enter DONE, and val_valid SHALL drop in the next cycle.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
  - start is ignored during DONE.
REQ-024 abort=1 in RUN SHALL return the FSM to IDLE on the next edge without a done pulse, and without a transfer on that edge even if out_ready=1.
  - abort takes priority over out_ready.
REQ-025 abort in IDLE or DONE SHALL have no effect.
REQ-026 start in RUN SHALL be ignored.
REQ-027 In IDLE, val_valid SHALL be 0 and val_out SHALL hold the last Q value.
REQ-028 wrap SHALL be tracked with a 1-bit "advanced" flag that is cleared at load and set on the first transfer.

Reset
REQ-029 While reset=0, all outputs and state SHALL take their reset values:
  - state IDLE, Q=4'b0001, counter=0
  - val_valid=0, busy=0, done=0, seed_err=0, wrap=0
  - val_out=4'b0001
REQ-030 Reset asserted mid-RUN SHALL abandon the run immediately with no done pulse.
REQ-031 After reset deasserts, start SHALL be accepted on the first clk edge.

Verification
REQ-032 seed=0001, steps=6, out_ready=1 -> val_out sequence 0001, 1000, 0100, 0010, 1001, 1100 on consecutive cycles, then done pulse one cycle, then busy=0.
REQ-033 seed=0000, steps=2 -> seed_err=1, val_out 0001 then 1000, done pulse.
REQ-034 seed=0001, steps=16, out_ready=1 -> wrap=1 only on the 16th value (val_out=0001).
REQ-035 seed=1001, steps=3, out_ready toggled 0/1 each cycle -> each value held while out_ready=0, sequence 1001, 1100, 0110, done after the 3rd transfer.
REQ-036 steps=0 with start -> no val_valid, done pulse in the cycle after start.
REQ-037 abort during RUN, and separately reset=0 during RUN -> val_valid=0 and busy=0 with no done pulse; a new start afterwards behaves as in REQ-032.
